serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 22 ++
 rtl/digit_sub_slice.sv | 32 +++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
//   state_t   : sequencing states for the multi-cycle arithmetic blocks
//   cnt_width : width of a digit counter that counts 0 .. n-1 (at least 1 bit)
//   DEF_WIDTH / DEF_DIGIT : default operand width and digit size
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DIGIT = 4;

  // A single-digit operation still needs a 1-bit counter so the port/reg
  // declarations stay legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_sub_slice.sv
// One DIGIT-bit subtract slice: d_d = a_d + ~b_d + cin, ripple-carry.
// Ports:
//   a_d  [DIGIT-1:0] in   minuend digit
//   b_d  [DIGIT-1:0] in   subtrahend digit (inverted internally)
//   cin              in   carry-in (inverted borrow)
//   d_d  [DIGIT-1:0] out  difference digit
//   cout             out  carry-out (inverted borrow)
module digit_sub_slice #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] d_d,
  output logic             cout
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    d_d  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      d_d[i]  = a_d[i] ^ ~b_d[i] ^ c[i];
      c[i+1]  = (a_d[i] & ~b_d[i]) | (a_d[i] & c[i]) | (~b_d[i] & c[i]);
    end
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin.
// One DIGIT-bit slice is reused WIDTH/DIGIT times, LSB digit first.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid / in_ready operand handshake (a, b, bin sampled at acceptance)
//   out_valid/out_ready result handshake (diff, bout, overflow held in DONE)
//   busy                high while digits are being processed
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             bout_q, ovf_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [DIGIT-1:0] a_dig_d, b_dig_d, dig_d;
  logic             cout_d;

  assign a_dig_d = a_q[cnt_q*DIGIT +: DIGIT];
  assign b_dig_d = b_q[cnt_q*DIGIT +: DIGIT];

  digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a_d  (a_dig_d),
    .b_d  (b_dig_d),
    .cin  (carry_q),
    .d_d  (dig_d),
    .cout (cout_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= ~bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          diff_q[cnt_q*DIGIT +: DIGIT] <= dig_d;
          carry_q <= cout_d;
          if (cnt_q == LAST) begin
            // The top digit is being written this cycle, so its MSB comes
            // straight from the slice rather than from diff_q.
            bout_q      <= ~cout_d;
            ovf_q       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (dig_d[DIGIT-1] ^ a_q[WIDTH-1]);
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(32), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic mov);
    longint sa, sb, sd;
    longint unsigned ua, ub;
    ua  = {32'b0, ma};
    ub  = {32'b0, mb};
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    sd  = sa - sb - longint'(mbin);
    md  = 32'(ua - ub - longint'(mbin));
    mbo = ua < (ub + longint'(mbin));
    mov = sd != longint'($signed(md));
  endfunction

  // Waits (bounded) for in_ready, presents one operand set, then scrambles
  // the operand inputs after acceptance.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    int unsigned n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 required 1");
      return;
    end
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
  endtask

  // Counts edges after acceptance until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    bit ok = 0;
    lat = 0;
    while (lat < 40 && !ok) begin
      @(posedge clk); #1; lat++;
      if (out_valid) ok = 1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL out_timeout: out_valid got 0 required 1");
    end
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    logic [W-1:0] md, na, nb;
    logic mbo, mov;

    vecs[0] = '{32'd5,        32'd3,        1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vecs[4] = '{32'd10,       32'd10,       1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{32'd10,       32'd10,       1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[6] = '{32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_diff",      64'(diff),      64'd0);
    check("rst_bout",      64'(bout),      64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].bin);
      check("busy_after_accept",     64'(busy),     64'd1);
      check("in_ready_after_accept", 64'(in_ready), 64'd0);
      wait_out(lat);
      check("latency",  64'(lat),      64'd8);
      check("diff",     64'(diff),     64'(vecs[i].diff));
      check("bout",     64'(bout),     64'(vecs[i].bout));
      check("overflow", 64'(overflow), 64'(vecs[i].ovf));
      @(posedge clk); #1;
      check("out_valid_one_cycle", 64'(out_valid), 64'd0);
      check("in_ready_back",       64'(in_ready),  64'd1);
    end

    // Backpressure: result held, new operands refused
    out_ready = 1'b0;
    accept(32'h12345678, 32'h00000078, 1'b0);
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      a = 32'd100; b = 32'd58; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_diff",      64'(diff),      64'h12345600);
      check("bp_bout",      64'(bout),      64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready",  64'(in_ready),  64'd1);
    check("bp_release_busy",      64'(busy),      64'd0);
    accept(32'd100, 32'd58, 1'b0);
    wait_out(lat);
    check("bp_next_diff", 64'(diff), 64'd42);

    // Reset in the middle of RUN
    accept(32'hDEADBEEF, 32'h01234567, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy",      64'(busy),      64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_result", 64'(out_valid), 64'd0);
    accept(32'd7, 32'd2, 1'b0);
    wait_out(lat);
    check("after_rst_latency", 64'(lat),  64'd8);
    check("after_rst_diff",    64'(diff), 64'd5);
    check("after_rst_bout",    64'(bout), 64'd0);
    @(posedge clk); #1;

    // Random operands vs. reference
    for (int i = 0; i < 1000; i++) begin
      na = $urandom;
      nb = $urandom;
      if (i % 4 == 1) nb = na;
      if (i % 8 == 3) na = {1'b1, 31'($urandom)} ^ {1'b0, nb[30:0]};
      mbo = 1'($urandom_range(0, 1));
      accept(na, nb, mbo);
      model(na, nb, mbo, md, mbo, mov);
      wait_out(lat);
      check("rnd_diff",     64'(diff),     64'(md));
      check("rnd_bout",     64'(bout),     64'(mbo));
      check("rnd_overflow", 64'(overflow), 64'(mov));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
